// File: rtl/orbit_pkg.sv
// Shared types, constants and trig helpers for the orbit stepper.
// Q1.8 sin/cos come from a 16-entry quarter-wave table.
package orbit_pkg;

  localparam int STEPS = 60;
  localparam int HALF_TURN = 30;
  localparam logic [7:0] KEY_CW = 8'd7;
  localparam logic [7:0] KEY_CCW = 8'd4;

  typedef enum logic [2:0] {
    IDLE,
    DECIDE,
    LOOK_RED,
    LOOK_BLUE,
    PUBLISH
  } state_t;

  typedef logic signed [9:0] trig_t;
  typedef logic [5:0] idx_t;

  function automatic trig_t quarter(input logic [3:0] k);
    trig_t v;
    case (k)
      4'd0: v = 10'sd0;
      4'd1: v = 10'sd27;
      4'd2: v = 10'sd53;
      4'd3: v = 10'sd79;
      4'd4: v = 10'sd104;
      4'd5: v = 10'sd128;
      4'd6: v = 10'sd150;
      4'd7: v = 10'sd171;
      4'd8: v = 10'sd190;
      4'd9: v = 10'sd207;
      4'd10: v = 10'sd222;
      4'd11: v = 10'sd234;
      4'd12: v = 10'sd243;
      4'd13: v = 10'sd250;
      4'd14: v = 10'sd255;
      4'd15: v = 10'sd256;
      default: v = 10'sd0;
    endcase
    return v;
  endfunction

  function automatic trig_t sin_q(input idx_t i);
    if (i <= 6'd15) return quarter(i[3:0]);
    else if (i <= 6'd30) return quarter(4'(6'd30 - i));
    else if (i <= 6'd45) return -quarter(4'(i - 6'd30));
    else return -quarter(4'(6'd60 - i));
  endfunction

  // cos(i) = sin(i + quarter turn)
  function automatic trig_t cos_q(input idx_t i);
    return sin_q((i >= 6'd45) ? i - 6'd45 : i + 6'd15);
  endfunction

  function automatic idx_t half(input idx_t i);
    return (i >= 6'(HALF_TURN)) ? i - 6'(HALF_TURN) : i + 6'(HALF_TURN);
  endfunction

  function automatic idx_t idx_inc(input idx_t i);
    return (i == 6'(STEPS - 1)) ? '0 : i + 6'd1;
  endfunction

  function automatic idx_t idx_dec(input idx_t i);
    return (i == '0) ? 6'(STEPS - 1) : i - 6'd1;
  endfunction

endpackage

// File: rtl/orbit_trig_rom.sv
// 60-entry Q1.8 cos/sin table, registered output, 1-cycle latency.
// Built from the quarter-wave helpers in orbit_pkg.
module orbit_trig_rom
  import orbit_pkg::*;
(
  input  logic              clk,
  input  logic              en,
  input  logic [5:0]        addr,
  output logic signed [9:0] cos_v,
  output logic signed [9:0] sin_v
);

  always_ff @(posedge clk)
    if (en) begin
      cos_v <= cos_q(addr);
      sin_v <= sin_q(addr);
    end

endmodule

// File: rtl/orbit_stepper.sv
// Two balls on a circular orbit, stepped by held rotate keys once per frame.
// Define ORBIT_OVERRUN_CNT_EN to count frame events dropped while busy.
module orbit_stepper
  import orbit_pkg::*;
#(
  parameter int RADIUS      = 80,
  parameter int CENTER_X    = 320,
  parameter int CENTER_Y    = 240,
  parameter int HOLD_FRAMES = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  output logic [5:0] index_red,
  output logic [5:0] index_blue,
  output logic [9:0] RedX,
  output logic [9:0] RedY,
  output logic [9:0] BlueX,
  output logic [9:0] BlueY,
  output logic       pos_valid,
  output logic [7:0] overrun_count
);

  localparam logic [9:0] CX = 10'(CENTER_X);
  localparam logic [9:0] CY = 10'(CENTER_Y);
  localparam logic [9:0] RX0 = 10'(CENTER_X + RADIUS);
  localparam logic [9:0] BX0 = 10'(CENTER_X - RADIUS);
  localparam logic signed [17:0] RAD = 18'(RADIUS);
  localparam logic [7:0] HOLD = 8'(HOLD_FRAMES);

  function automatic logic [9:0] offs(input trig_t t);
    logic signed [17:0] s;
    s = RAD * $signed({{8{t[9]}}, t}) + 18'sd128;
    return 10'(s >>> 8);
  endfunction

  state_t     state, nstate;
  logic [2:0] fsync;
  logic       fevent;
  idx_t       idx, pub_idx, rom_addr;
  logic [7:0] last_key, hold_cnt, cnt_inc;
  logic       rot, fresh, hold_hit, step, rom_en;
  trig_t      rom_cos, rom_sin;
  logic [9:0] red_dx, red_dy;
  logic [9:0] pub_rx, pub_ry, pub_bx, pub_by;
  logic [9:0] new_rx, new_ry, new_bx, new_by;

  // two sync flops, third flop only remembers the previous level
  always_ff @(posedge Clk)
    if (Reset) fsync <= '0;
    else fsync <= {fsync[1:0], frame_clk};

  assign fevent = fsync[1] & ~fsync[2];

  always_ff @(posedge Clk)
    if (Reset) state <= IDLE;
    else state <= nstate;

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:      if (fevent) nstate = DECIDE;
      DECIDE:    nstate = LOOK_RED;
      LOOK_RED:  nstate = LOOK_BLUE;
      LOOK_BLUE: nstate = PUBLISH;
      PUBLISH:   nstate = IDLE;
      default:   nstate = IDLE;
    endcase
  end

  assign rot = (keycode == KEY_CW) || (keycode == KEY_CCW);
  assign fresh = keycode != last_key;
  assign cnt_inc = hold_cnt + 8'd1;
  assign hold_hit = cnt_inc >= HOLD;
  assign step = rot && (fresh || hold_hit);

  always_ff @(posedge Clk)
    if (Reset) begin
      idx <= '0;
      last_key <= '0;
      hold_cnt <= '0;
    end else if (state == DECIDE) begin
      last_key <= keycode;
      hold_cnt <= (rot && !step) ? cnt_inc : '0;
      if (step)
        idx <= (keycode == KEY_CCW) ? idx_inc(idx) : idx_dec(idx);
    end

  assign rom_en = (state == LOOK_RED) || (state == LOOK_BLUE);
  assign rom_addr = (state == LOOK_BLUE) ? half(idx) : idx;

  orbit_trig_rom u_rom (
    .clk   (Clk),
    .en    (rom_en),
    .addr  (rom_addr),
    .cos_v (rom_cos),
    .sin_v (rom_sin)
  );

  always_ff @(posedge Clk)
    if (state == LOOK_BLUE) begin
      red_dx <= offs(rom_cos);
      red_dy <= offs(rom_sin);
    end

  assign new_rx = CX + red_dx;
  assign new_ry = CY - red_dy;
  assign new_bx = CX + offs(rom_cos);
  assign new_by = CY - offs(rom_sin);

  assign pos_valid = (state == PUBLISH) && !Reset;

  always_ff @(posedge Clk)
    if (Reset) begin
      pub_idx <= '0;
      pub_rx <= RX0;
      pub_ry <= CY;
      pub_bx <= BX0;
      pub_by <= CY;
    end else if (pos_valid) begin
      pub_idx <= idx;
      pub_rx <= new_rx;
      pub_ry <= new_ry;
      pub_bx <= new_bx;
      pub_by <= new_by;
    end

  // new frame shows through in PUBLISH, then the held copy takes over
  assign index_red = pos_valid ? idx : pub_idx;
  assign index_blue = half(index_red);
  assign RedX = pos_valid ? new_rx : pub_rx;
  assign RedY = pos_valid ? new_ry : pub_ry;
  assign BlueX = pos_valid ? new_bx : pub_bx;
  assign BlueY = pos_valid ? new_by : pub_by;

`ifdef ORBIT_OVERRUN_CNT_EN
  logic [7:0] ovr;

  always_ff @(posedge Clk)
    if (Reset) ovr <= '0;
    else if (fevent && state != IDLE && ovr != 8'hFF) ovr <= ovr + 8'd1;

  assign overrun_count = ovr;
`else
  assign overrun_count = '0;
`endif

endmodule

// File: tb/tb_orbit_stepper.sv
// Scoreboard bench for orbit_stepper: expected frames queued at stimulus,
// popped and compared on pos_valid.
module tb_orbit_stepper;

  localparam int R = 80;
  localparam int CX = 320;
  localparam int CY = 240;
  localparam int HOLD = 2;

  typedef struct {
    int ir;
    int ib;
    int rx;
    int ry;
    int bx;
    int by;
  } exp_t;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic [7:0] keycode;
  logic [5:0] index_red, index_blue;
  logic [9:0] RedX, RedY, BlueX, BlueY;
  logic       pos_valid;
  logic [7:0] overrun_count;

  exp_t sb[$];
  int n_run = 0;
  int n_fail = 0;
  int m_idx, m_last, m_run;
  int keys[8] = '{0, 4, 4, 7, 7, 9, 4, 4};

  orbit_stepper #(
    .RADIUS(R), .CENTER_X(CX), .CENTER_Y(CY), .HOLD_FRAMES(HOLD)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
    .index_red(index_red), .index_blue(index_blue),
    .RedX(RedX), .RedY(RedY), .BlueX(BlueX), .BlueY(BlueY),
    .pos_valid(pos_valid), .overrun_count(overrun_count)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input int got, input int exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int rnd(real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

  function automatic int trig(bit c, int i);
    real a = 3.14159265358979 * 6.0 * i / 180.0;
    return rnd(256.0 * (c ? $cos(a) : $sin(a)));
  endfunction

  function automatic int off(bit c, int i);
    return (R * trig(c, i) + 128) >>> 8;
  endfunction

  function automatic exp_t make_exp(int i);
    exp_t e;
    int b = (i + 30) % 60;
    e.ir = i;
    e.ib = b;
    e.rx = (CX + off(1'b1, i)) & 1023;
    e.ry = (CY - off(1'b0, i)) & 1023;
    e.bx = (CX + off(1'b1, b)) & 1023;
    e.by = (CY - off(1'b0, b)) & 1023;
    return e;
  endfunction

  task automatic model_reset();
    m_idx = 0;
    m_last = 0;
    m_run = 0;
  endtask

  // run length since the key changed; step every HOLD-th frame of a run
  task automatic model_frame(input int k);
    if (k == m_last) m_run++;
    else m_run = 0;
    if ((k == 4 || k == 7) && (m_run % HOLD) == 0)
      m_idx = (k == 4) ? (m_idx + 1) % 60 : (m_idx + 59) % 60;
    m_last = k;
    sb.push_back(make_exp(m_idx));
  endtask

  task automatic pop_check();
    exp_t e;
    check("sb_nonempty", int'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("index_red", index_red, e.ir);
      check("index_blue", index_blue, e.ib);
      check("RedX", RedX, e.rx);
      check("RedY", RedY, e.ry);
      check("BlueX", BlueX, e.bx);
      check("BlueY", BlueY, e.by);
    end
  endtask

  task automatic frame(input logic [7:0] k);
    int first = -1;
    int n = 0;
    keycode = k;
    model_frame(int'(k));
    frame_clk = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge Clk);
      if (c == 4) frame_clk = 1'b0;
      if (pos_valid) begin
        n++;
        if (first < 0) first = c;
        pop_check();
      end
    end
    check("latency", first, 6);
    check("pulses", n, 1);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    frame_clk = 1'b0;
    keycode = 8'd0;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int n, first, ovr_exp;
    Reset = 1'b1;
    frame_clk = 1'b0;
    keycode = 8'd0;
    repeat (3) @(negedge Clk);
    check("rst_pos_valid", pos_valid, 0);
    check("rst_index_red", index_red, 0);
    check("rst_index_blue", index_blue, 30);
    check("rst_RedX", RedX, CX + R);
    check("rst_RedY", RedY, CY);
    check("rst_BlueX", BlueX, CX - R);
    check("rst_BlueY", BlueY, CY);
    check("rst_overrun", overrun_count, 0);
    Reset = 1'b0;
    model_reset();

    frame(8'd0);

    do_reset();
    frame(8'd4);

    do_reset();
    frame(8'd7);
    frame(8'd4);

    do_reset();
    repeat (6) frame(8'd4);
    check("hold_final", index_red, 3);

    // abort: publish idx 1, then reset mid-frame in LOOK_RED
    do_reset();
    frame(8'd4);
    keycode = 8'd0;
    frame_clk = 1'b1;
    repeat (4) @(negedge Clk);
    Reset = 1'b1;
    frame_clk = 1'b0;
    @(negedge Clk);
    check("abort_pos_valid", pos_valid, 0);
    check("abort_index_red", index_red, 0);
    check("abort_index_blue", index_blue, 30);
    check("abort_RedX", RedX, CX + R);
    check("abort_RedY", RedY, CY);
    check("abort_BlueX", BlueX, CX - R);
    check("abort_BlueY", BlueY, CY);
    Reset = 1'b0;
    model_reset();
    n = 0;
    repeat (10) begin
      @(negedge Clk);
      if (pos_valid) n++;
    end
    check("abort_pulses", n, 0);
    frame(8'd4);

    // second edge two cycles after the first lands while busy
    do_reset();
    keycode = 8'd0;
    model_frame(0);
    frame_clk = 1'b1;
    first = -1;
    n = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge Clk);
      if (c == 1) frame_clk = 1'b0;
      if (c == 2) frame_clk = 1'b1;
      if (c == 5) frame_clk = 1'b0;
      if (pos_valid) begin
        n++;
        if (first < 0) first = c;
        pop_check();
      end
    end
    check("ovr_latency", first, 6);
    check("ovr_pulses", n, 1);
`ifdef ORBIT_OVERRUN_CNT_EN
    ovr_exp = 1;
`else
    ovr_exp = 0;
`endif
    check("overrun_count", overrun_count, ovr_exp);

    do_reset();
    repeat (40) frame(8'(keys[$urandom_range(0, 7)]));
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
